fifo_flops_param: RTL

//  Parametrised flop-based synchronous FIFO; successor to the basic push/pop/full/pndng FIFO.

---
 rtl/fifo_flops_param.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_flops_param.sv
// Flop-based synchronous FIFO with arbitrary depth, occupancy count, threshold flags,
// sticky overflow/underflow errors and selectable first-word-fall-through or registered read.
module fifo_flops_param #(
  parameter int depth    = 8,
  parameter int bits     = 16,
  parameter int AF_LEVEL = depth - 2,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [bits-1:0]            Din,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [bits-1:0]            Dout,
  output logic                       full,
  output logic                       pndng,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = (depth > 2) ? $clog2(depth) : 1;

  if (depth < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > depth) begin : g_bad_params
    $error("fifo_flops_param: need depth>=2 and 0 <= AE_LEVEL < AF_LEVEL <= depth");
  end

  logic [bits-1:0] mem [depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            pop_acc;
  logic            push_acc;

  // Acceptance depends only on registered count, so a full FIFO can take a push alongside a pop.
  always_comb begin
    pop_acc  = pop && (count != '0);
    push_acc = push && ((count < CW'(depth)) || pop_acc);
  end

  always_comb begin
    full         = (count == CW'(depth));
    pndng        = (count != '0);
    almost_full  = (count >= CW'(AF_LEVEL));
    almost_empty = (count <= CW'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= Din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= (wr_ptr == PW'(depth - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop_acc)  rd_ptr <= (rd_ptr == PW'(depth - 1)) ? '0 : rd_ptr + PW'(1);
      if (push_acc && !pop_acc)      count <= count + CW'(1);
      else if (!push_acc && pop_acc) count <= count - CW'(1);
      // A new error in the same cycle as clr_err keeps the flag set.
      if (push && !push_acc) overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (pop && !pop_acc)   underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign Dout = pndng ? mem[rd_ptr] : '0;
  end else begin : g_regread
    logic [bits-1:0] dout_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         dout_q <= '0;
      else if (pop_acc) dout_q <= mem[rd_ptr];
    end
    assign Dout = dout_q;
  end

endmodule
